bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters (name, default, meaning): AddrWidth, 32, address width; DataWidth, 32, data width, a multiple of 8; NumReq, 2, number of requesters, at least 2; MaxOutstanding, 4, maximum accepted requests awaiting rvalid, a power of 2.
REQ-002 Ports (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- rst_ni, in, 1, asynchronous active-low reset.
- req_valid_i, in, NumReq, per-requester request valid.
- req_ready_o, out, NumReq, per-requester accept.
- req_addr_i, in, NumReq x AddrWidth, per-requester address.
- req_wdata_i, in, NumReq x DataWidth, per-requester write data.
- req_wmask_i, in, NumReq x DataWidth/8, per-requester byte write mask; zero means read.
- req_rdata_o, out, NumReq x DataWidth, response data.
- req_rvalid_o, out, NumReq, response strobe.
- mem_valid_o, out, 1, request to the shared responder.
- mem_ready_i, in, 1, responder accept.
- mem_addr_o, out, AddrWidth, forwarded address.
- mem_wdata_o, out, DataWidth, forwarded write data.
- mem_wmask_o, out, DataWidth/8, forwarded byte mask.
- mem_rdata_i, in, DataWidth, responder data.
- mem_rvalid_i, in, 1, responder response strobe.
- err_o, out, 1, sticky protocol-error flag.

Function
REQ-003 Handshake: a transfer occurs on a rising clk_i edge when valid and ready are both high; every accepted request, read or write, yields exactly one mem_rvalid_i; responses return in acceptance order.
REQ-004 States: ARB (no request held) and HOLD (grant locked); grant index held in register gnt_q.
REQ-005 ARB: if any req_valid_i and outstanding FIFO not full, pick a winner combinationally; mem_valid_o=1; mem_addr_o, mem_wdata_o and mem_wmask_o are driven from the winner in the same cycle (zero latency).
REQ-006 ARB with the winner valid and mem_ready_i=0: go to HOLD, gnt_q = winner.
REQ-007 HOLD: the grant stays fixed on gnt_q regardless of other requests; mem_valid_o=1; on mem_ready_i=1 the request is accepted and the next state is ARB.
REQ-008 req_ready_o[i] = mem_ready_i AND mem_valid_o AND (granted index == i); all other bits are 0.
REQ-009 On each accept, push the granted index into the outstanding FIFO.
REQ-010 On mem_rvalid_i with the FIFO non-empty: req_rvalid_o[head]=1 in the same cycle, then pop; req_rdata_o of every requester = mem_rdata_i (a broadcast, qualified only by rvalid).
REQ-011 FIFO full: mem_valid_o=0 in ARB and no new grant is made. Simultaneous pop when full does not permit a same-cycle push.
REQ-012 Simultaneous push and pop when not full: both take effect; count unchanged.
REQ-013 mem_rvalid_i with the FIFO empty: the response is dropped, no req_rvalid_o, err_o set to 1 until reset.
REQ-014 A request that a requester deasserts while in HOLD is a requester protocol violation; the block keeps forwarding gnt_q and does not flag it.
REQ-015 FIFO pointers wrap modulo MaxOutstanding; the count is log2(MaxOutstanding)+1 bits wide.

Reset
REQ-016 While rst_ni=0, asynchronously: state=ARB, gnt_q=0, FIFO empty, round-robin pointer=0, err_o=0, mem_valid_o=0, req_ready_o=0, req_rvalid_o=0.
REQ-017 Reset mid-transaction discards all outstanding entries; a response arriving after reset is treated per REQ-013.

Configuration
REQ-018 Macro BUS_ARBITER_ROUND_ROBIN_EN:
- Defined: the winner is the first valid requester at or after rr_q, searching upward with wrap; on accept, rr_q = winner+1 mod NumReq.
- Undefined: fixed priority, lowest index wins; rr_q is absent.

Structure
REQ-019 Package bus_arbiter_pkg holds the state enum (ARB, HOLD) and the requester-index typedef.
REQ-020 Sub-module bus_arbiter_id_fifo is the outstanding-index FIFO, with push, pop, full, empty and head.

Verification
REQ-021 Requester 0 reads 0x100 with mem_ready_i=1, then rvalid two cycles later with rdata 0xDEADBEEF: req_ready_o=01 in the same cycle; req_rvalid_o=01 with rdata 0xDEADBEEF.
REQ-022 Both requesters valid every cycle, ready always 1, ROUND_ROBIN_EN defined: grants alternate 0,1,0,1. With the macro undefined: all grants go to 0.
REQ-023 Requester 1 valid with mem_ready_i=0 for 3 cycles, requester 0 asserting in cycle 2: grant stays on 1 until accept; requester 0 is served next.
REQ-024 Four accepts with no rvalid: the fifth request sees mem_valid_o=0; one rvalid frees a slot and the next cycle accepts.
REQ-025 mem_rvalid_i pulse after reset with no request: no req_rvalid_o; err_o=1 and held.
REQ-026 Interleaved grants 1,0,1 with rvalid data A,B,C: rvalid is routed to 1,0,1 with A,B,C respectively.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types for the bus arbiter: FSM state encoding, the requester-index
// type carried through the grant register and the outstanding-response FIFO,
// and a small wrap-around helper used by the round-robin pointer.
package bus_arbiter_pkg;

    // Width of a requester index; sized for up to 16 requesters.
    localparam int IdxWidth = 4;

    typedef logic [IdxWidth-1:0] req_idx_t;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Next requester index after idx, wrapping back to zero at num_req.
    function automatic req_idx_t next_idx(input req_idx_t idx, input int num_req);
        req_idx_t result;
        if (int'(idx) + 1 >= num_req) begin
            result = '0;
        end else begin
            result = idx + req_idx_t'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_arbiter_id_fifo.sv
// Outstanding-request FIFO for the bus arbiter. Each accepted request pushes
// the index of the requester that issued it; each responder strobe pops the
// head so the response can be routed back in acceptance order.
// Depth must be a power of two (at least 2) so the pointers wrap naturally.
module bus_arbiter_id_fifo
    import bus_arbiter_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push,
    input  req_idx_t push_idx,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output req_idx_t head
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth) + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(Depth);

    req_idx_t        slots_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    // Full and empty come straight from the registered count, so a pop in the
    // same cycle never opens room for a push while full.
    always_comb begin
        full    = (count_q == FullCount);
        empty   = (count_q == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = slots_q[rd_ptr_q];
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
    // the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Slot storage needs no reset; only slots behind valid pointers are read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            slots_q[wr_ptr_q] <= push_idx;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Multi-requester arbiter in front of a single shared memory responder.
// A winner is chosen combinationally and forwarded with zero latency; if the
// responder stalls, the grant is locked until it accepts. Accepted requester
// indices are queued so in-order responses can be routed back.
// Optional build macro: BUS_ARBITER_ROUND_ROBIN_EN selects round-robin
// arbitration; without it the lowest-index valid requester always wins.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int NumReq         = 2,
    parameter int MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumReq-1:0]                    req_valid_i,
    output logic [NumReq-1:0]                    req_ready_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]     req_wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]   req_wmask_i,
    output logic [NumReq-1:0][DataWidth-1:0]     req_rdata_o,
    output logic [NumReq-1:0]                    req_rvalid_o,
    output logic                                 mem_valid_o,
    input  logic                                 mem_ready_i,
    output logic [AddrWidth-1:0]                 mem_addr_o,
    output logic [DataWidth-1:0]                 mem_wdata_o,
    output logic [DataWidth/8-1:0]               mem_wmask_o,
    input  logic [DataWidth-1:0]                 mem_rdata_i,
    input  logic                                 mem_rvalid_i,
    output logic                                 err_o
);

    arb_state_e state_q;
    req_idx_t   gnt_q;
    req_idx_t   winner;
    req_idx_t   grant_idx;
    logic       winner_found;
    logic       any_valid;
    logic       accept;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    req_idx_t   fifo_head;
    logic       err_q;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    req_idx_t          rr_q;
    logic [NumReq-1:0] rotated;
    int                cand;

    // Round-robin pick: rotate the request vector so rr_q sits at bit 0, take
    // the first set bit, then map the position back to a requester index.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand         = 0;
        rotated      = NumReq'({req_valid_i, req_valid_i} >> rr_q);
        for (int i = 0; i < NumReq; i++) begin
            if (!winner_found && rotated[i]) begin
                winner_found = 1'b1;
                cand         = int'(rr_q) + i;
                if (cand >= NumReq) begin
                    cand = cand - NumReq;
                end
                winner = req_idx_t'(cand);
            end
        end
    end

    // The pointer moves just past whichever requester was accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (accept) begin
            rr_q <= next_idx(grant_idx, NumReq);
        end
    end
`else
    // Fixed-priority pick: the lowest-index valid requester wins.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (!winner_found && req_valid_i[i]) begin
                winner_found = 1'b1;
                winner       = req_idx_t'(i);
            end
        end
    end
`endif

    // Grant selection and request qualification; nothing is offered while in
    // reset, and in ARB a full FIFO blocks any new grant.
    always_comb begin
        any_valid   = |req_valid_i;
        grant_idx   = (state_q == HOLD) ? gnt_q : winner;
        mem_valid_o = 1'b0;
        if (rst_ni) begin
            unique case (state_q)
                ARB:     mem_valid_o = any_valid && !fifo_full;
                HOLD:    mem_valid_o = 1'b1;
                default: mem_valid_o = 1'b0;
            endcase
        end
        accept = mem_valid_o && mem_ready_i;
        pop    = mem_rvalid_i && !fifo_empty;
    end

    // Forward the granted requester's payload and steer accept back to it.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        req_ready_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant_idx == req_idx_t'(i)) begin
                mem_addr_o     = req_addr_i[i];
                mem_wdata_o    = req_wdata_i[i];
                mem_wmask_o    = req_wmask_i[i];
                req_ready_o[i] = accept;
            end
        end
    end

    // Responses go to the requester at the FIFO head; data is broadcast.
    always_comb begin
        req_rvalid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_rdata_o[i] = mem_rdata_i;
            if (fifo_head == req_idx_t'(i)) begin
                req_rvalid_o[i] = pop;
            end
        end
    end

    // Grant-lock FSM plus the sticky flag for responses nobody is waiting for.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            gnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ARB: begin
                    if (mem_valid_o && !mem_ready_i) begin
                        state_q <= HOLD;
                        gnt_q   <= winner;
                    end
                end
                HOLD: begin
                    if (mem_ready_i) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
            if (mem_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;

    bus_arbiter_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (accept),
        .push_idx (grant_idx),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

endmodule
